uart_xcvr: RTL
==============

Name: uart_xcvr

Overview:
Synthesisable, parametrised UART transceiver that replaces the simulation-only UART task model with real RTL.
- TX: valid/ready byte interface, serialised onto `tx`.
- RX: 16x oversampled receiver on `rx`, with parity and framing checks.
- Sits between on-chip debug/console logic and the board UART pins; also usable as a bench-side model.

Parameters:
CLK_DIV, 54, clock cycles per 16x oversample tick (clk_freq / (baud*16)); legal range ≥2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2; TX emits this many stop bits, RX checks only the first.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tx_data  in  DATA_BITS  byte to send, LSB first
tx_valid  in  1  TX request
tx_ready  out  1  TX idle; a transfer occurs when tx_valid && tx_ready
tx  out  1  serial output, idle high
rx  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  received data, valid with rx_valid
rx_valid  out  1  one-cycle pulse per received frame
rx_perr  out  1  parity error, qualified by rx_valid
rx_ferr  out  1  framing error (stop bit low), qualified by rx_valid

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0; tick counters=0; both FSMs in IDLE.
- Reset mid-frame abandons the frame; tx=1 from the next edge.
- Tick generator: divider counts 0..CLK_DIV-1 and pulses `tick` on wrap. One bit period = 16 ticks = 16*CLK_DIV cycles.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - On accept, tx_data is latched and tx_ready drops on the next edge.
  - tx=0 from the cycle after accept. Each state holds for exactly 16 ticks; the bit-tick counter restarts on accept.
  - DATA shifts out DATA_BITS bits, LSB first.
  - PARITY state is present only if PARITY≠0: odd => bit = ~^data; even => bit = ^data.
  - STOP drives 1 for STOP_BITS periods, then IDLE with tx_ready=1.
  - tx_valid while busy is ignored; the requester holds tx_valid until ready.
- RX synchroniser: 2-flop synchroniser on rx feeds all RX logic (2-cycle added latency).
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (BRK) -> IDLE.
  - IDLE: synced rx low => START, oversample counter cleared.
  - START: sample at tick 8 (mid-bit). If high, false start => IDLE, no output. Glitches shorter than ~8 ticks never produce rx_valid.
  - DATA: samples at tick 8 of each subsequent bit into a shift register.
  - PARITY: compares the sampled bit with the computed parity and sets the internal perr.
  - STOP: samples mid-bit. rx_valid pulses for one cycle on that sample with rx_data, rx_perr and rx_ferr = ~sample.
  - After STOP: if the sample was 1 => IDLE immediately (mid-stop, allowing back-to-back frames). Otherwise => BRK.
  - BRK waits until synced rx = 1, then IDLE. A held-low break line yields exactly one frame with rx_data=0 and rx_ferr=1.
- Error outputs: rx_data, rx_perr and rx_ferr hold their value until the next rx_valid.
- No RX backpressure: downstream must consume on the pulse.
- TX and RX are fully independent; simultaneous activity on both is legal.

Optional Feature:
UART_LOOPBACK_EN: adds input port `loopback` (1 bit).
- When loopback=1, the RX synchroniser input is the internal TX serial bit, and the `tx` pin is held 1.
- When loopback=0, normal operation.
- Without the macro the port does not exist and RX always uses the `rx` pin.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - TX and RX state enumerations;
  - OVERSAMPLE=16 and SAMPLE_POINT=8 constants.
- One natural sub-module: uart_tick_gen, the CLK_DIV divider producing `tick`.
  - Instantiated twice: TX and RX keep independent phase, and the RX divider is realigned on start-edge detect.

Test Plan:
- CLK_DIV=4, 8N1, send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 each held 64 cycles; tx_ready high again 640 cycles after accept.
- 8E1, tx looped to rx externally, send 0xA3 -> parity bit 0 on tx; exactly one rx_valid with rx_data=0xA3, rx_perr=0, rx_ferr=0.
- 8E1, bench drives frame data 0x01 with parity bit 0 -> rx_valid, rx_data=0x01, rx_perr=1.
- 7O2, send 0x7F -> 7 data bits of 1, parity bit 0, two stop periods (11 bit periods total); RX loop returns 0x7F with no errors.
- rx low for 12 cycles (CLK_DIV=4) -> no rx_valid. rx low for 20 bit periods -> one rx_valid with rx_data=0x00, rx_ferr=1, and none further until rx returns high.
- Assert rst for 1 cycle during TX data bit 3 -> tx=1 and tx_ready=1 next cycle; a following 0x3C transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encodings for the uart_xcvr transceiver.
//   - Parity mode encodings used by the PARITY parameter.
//   - Oversampling ratio and mid-bit sample point.
//   - TX and RX FSM state enumerations.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned OVERSAMPLE   = 16;
    localparam int unsigned SAMPLE_POINT = 8;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxBrk
    } rx_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: oversample tick divider.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clr   in  synchronous phase realign; counter restarts at 0
//   tick  out one-cycle pulse every CLK_DIV cycles (when the counter wraps)
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised UART transceiver (valid/ready TX, 16x oversampled RX).
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   loopback  in  (only with UART_LOOPBACK_EN) route internal TX bit to RX, hold tx pin high
//   tx_data   in  DATA_BITS word to send, LSB first
//   tx_valid  in  TX request
//   tx_ready  out TX idle; transfer when tx_valid && tx_ready
//   tx        out serial output, idle high
//   rx        in  serial input, asynchronous
//   rx_data   out received word, held until the next rx_valid
//   rx_valid  out one-cycle pulse per received frame
//   rx_perr   out parity error, qualified by rx_valid
//   rx_ferr   out framing error (first stop bit low), qualified by rx_valid
// Optional feature macro: UART_LOOPBACK_EN.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 54,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_perr,
    output logic                 rx_ferr
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned BW   = 3;

    // ---------------------------------------------------------------- TX
    tx_state_e             tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic [OS_W-1:0]       tx_os_q, tx_os_d;
    logic [BW-1:0]         tx_bit_q, tx_bit_d;
    logic                  tx_q, tx_d;
    logic                  tx_tick, tx_clr, tx_bit_end;

    uart_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tx_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tx_clr),
        .tick (tx_tick)
    );

    assign tx_bit_end = tx_tick && (tx_os_q == OS_W'(OVERSAMPLE - 1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_clr     = 1'b0;
        if (tx_tick) begin
            tx_os_d = tx_os_q + OS_W'(1);
        end
        unique case (tx_state_q)
            TxIdle: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    // Restart the divider so the start bit lasts exactly one bit period.
                    tx_state_d = TxStart;
                    tx_shift_d = tx_data;
                    tx_par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                    tx_os_d    = '0;
                    tx_bit_d   = '0;
                    tx_clr     = 1'b1;
                    tx_d       = 1'b0;
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_state_d = TxData;
                    tx_d       = tx_shift_q[0];
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            tx_state_d = TxParity;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TxStop;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + BW'(1);
                        tx_d     = tx_shift_d[0];
                    end
                end
            end
            TxParity: begin
                if (tx_bit_end) begin
                    tx_state_d = TxStop;
                    tx_d       = 1'b1;
                end
            end
            TxStop: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BW'(STOP_BITS - 1)) begin
                        tx_state_d = TxIdle;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + BW'(1);
                    end
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_ready = (tx_state_q == TxIdle);

    // ------------------------------------------------------ pin routing
    logic rx_src;

`ifdef UART_LOOPBACK_EN
    assign tx     = loopback ? 1'b1 : tx_q;
    assign rx_src = loopback ? tx_q : rx;
`else
    assign tx     = tx_q;
    assign rx_src = rx;
`endif

    // ---------------------------------------------------------------- RX
    logic [1:0]            rx_sync_q;
    logic                  rxs;
    rx_state_e             rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic [OS_W-1:0]       rx_os_q, rx_os_d;
    logic [BW-1:0]         rx_bit_q, rx_bit_d;
    logic                  rx_pint_q, rx_pint_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic                  rx_tick, rx_clr, rx_mid, rx_exp_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_src};
        end
    end

    assign rxs = rx_sync_q[1];

    uart_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_rx_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_clr),
        .tick (rx_tick)
    );

    // After the start-bit check the counter restarts, so the 16th tick of a bit is mid-bit.
    assign rx_mid     = rx_tick && (rx_os_q == OS_W'(OVERSAMPLE - 1));
    assign rx_exp_par = (PARITY == PAR_ODD) ? ~^rx_shift_q : ^rx_shift_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_pint_d  = rx_pint_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
        rx_clr     = 1'b0;
        if (rx_tick) begin
            rx_os_d = rx_os_q + OS_W'(1);
        end
        unique case (rx_state_q)
            RxIdle: begin
                if (!rxs) begin
                    rx_state_d = RxStart;
                    rx_os_d    = '0;
                    rx_clr     = 1'b1;
                end
            end
            RxStart: begin
                if (rx_tick && (rx_os_q == OS_W'(SAMPLE_POINT - 1))) begin
                    if (rxs) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxData;
                        rx_os_d    = '0;
                        rx_bit_d   = '0;
                        rx_pint_d  = 1'b0;
                    end
                end
            end
            RxData: begin
                if (rx_mid) begin
                    rx_shift_d = {rxs, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BW'(DATA_BITS - 1)) begin
                        rx_bit_d   = '0;
                        rx_state_d = (PARITY != PAR_NONE) ? RxParity : RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end
            end
            RxParity: begin
                if (rx_mid) begin
                    rx_pint_d  = rxs ^ rx_exp_par;
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_mid) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = rx_pint_q;
                    rx_ferr_d  = ~rxs;
                    // Leaving mid-stop lets a back-to-back start edge be caught.
                    rx_state_d = rxs ? RxIdle : RxBrk;
                end
            end
            RxBrk: begin
                if (rxs) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            rx_shift_q <= '0;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_pint_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_pint_q  <= rx_pint_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_perr  = rx_perr_q;
    assign rx_ferr  = rx_ferr_q;

endmodule
